// File: rtl/mod_red_sm2p_512.sv
// Reduces a 512-bit product modulo the SM2 prime. It repeatedly folds the upper half
// back into the lower half, then does one final conditional subtraction.
module mod_red_sm2p_512 (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           red_vld_i,
    input  logic [511:0]   red_d_i,
    output logic           red_busy_o,
    output logic           red_fin_o,
    output logic [255:0]   red_r_o
);
    localparam int unsigned DW = 512;
    localparam int unsigned RW = 256;
    localparam int unsigned CW = 4;
    localparam logic [RW-1:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {IDLE, FOLD, CORR} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   x_q, x_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   r_q, r_d;
    logic            fin_q, fin_d;
    logic            busy_q, busy_d;

    logic [DW-1:0]   h_ext, l_ext, fold;
    logic [RW-1:0]   x_lo;

    // 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p).
    always_comb begin
        h_ext = DW'(x_q[DW-1:RW]);
        l_ext = DW'(x_q[RW-1:0]);
        x_lo  = x_q[RW-1:0];
        fold  = l_ext + (h_ext << 224) + (h_ext << 96) - (h_ext << 64) + h_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        fin_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (red_vld_i) begin
                    x_d     = red_d_i;
                    cnt_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                if (x_q[DW-1:RW] != '0) begin
                    x_d   = fold;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d = CORR;
                end
            end
            CORR: begin
                // The value is below 2^256 < 2p here, so one subtraction is enough.
                r_d     = (x_lo >= P) ? (x_lo - P) : x_lo;
                fin_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign red_busy_o = busy_q;
    assign red_fin_o  = fin_q;
    assign red_r_o    = r_q;
endmodule

// File: tb/tb_mod_red_sm2p_512.sv
// Scoreboard bench for mod_red_sm2p_512: expected residues are computed with
// plain wide modulo and checked by an independent completion monitor.
module tb_mod_red_sm2p_512;
    localparam logic [255:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam int NUM_RAND = 8000;

    typedef struct {
        logic [255:0] r;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         red_vld_i;
    logic [511:0] red_d_i;
    logic         red_busy_o;
    logic         red_fin_o;
    logic [255:0] red_r_o;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    mod_red_sm2p_512 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .red_vld_i  (red_vld_i),
        .red_d_i    (red_d_i),
        .red_busy_o (red_busy_o),
        .red_fin_o  (red_fin_o),
        .red_r_o    (red_r_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] ref_mod(input logic [511:0] d);
        logic [511:0] pw;
        pw = {256'b0, P};
        return 256'(d % pw);
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        int           w;
        v = '0;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        w = $urandom_range(0, 512);
        if (w < 512) v = v & ((512'(1) << w) - 512'(1));
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Record an expectation for an acceptance at the next clock edge.
    task automatic push(input logic [255:0] r, input int lat);
        exp_t e;
        e.r   = r;
        e.acc = cyc + 1;
        e.lat = lat;
        q.push_back(e);
    endtask

    task automatic issue(input logic [511:0] d, input logic [255:0] r, input int lat);
        red_vld_i = 1'b1;
        red_d_i   = d;
        push(r, lat);
        @(posedge clk); #1;
        red_vld_i = 1'b0;
        red_d_i   = rnd512();
        check("busy_after_accept", 256'(red_busy_o), 256'(1));
    endtask

    task automatic wait_fin();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!red_fin_o && n < 20);
        if (!red_fin_o) begin
            total++;
            bad++;
            $display("FAIL fin_timeout: got no red_fin_o within %0d cycles, want a pulse", n);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && red_fin_o) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_fin: got red_fin_o with r=%h, want no pulse", red_r_o);
            end else begin
                exp_t e;
                int   lat;
                e   = q.pop_front();
                lat = cyc - e.acc;
                check("result", red_r_o, e.r);
                check("busy_at_fin", 256'(red_busy_o), 256'(0));
                total++;
                if (e.lat >= 0 ? (lat != e.lat) : (lat < 2 || lat > 14)) begin
                    bad++;
                    $display("FAIL latency: got %0d want %0d (-1 means 2..14)", lat, e.lat);
                end
            end
        end
    end

    initial begin
        logic [511:0] v, pm1w;
        logic [255:0] e229;

        rst_n     = 1'b1;
        red_vld_i = 1'b0;
        red_d_i   = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 256'(red_busy_o), 256'(0));
        check("rst_fin",  256'(red_fin_o),  256'(0));
        check("rst_r",    red_r_o,          256'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed corner values with exact latency.
        issue(512'd0, 256'd0, 2);
        wait_fin();
        issue({256'b0, P}, 256'd0, 2);
        wait_fin();
        issue({256'b0, P - 256'd1}, P - 256'd1, 2);
        wait_fin();
        v = '0;
        v[256] = 1'b1;
        e229 = (256'(1) << 224) + (256'(1) << 96) - (256'(1) << 64) + 256'(1);
        issue(v, e229, 3);
        wait_fin();
        pm1w = {256'b0, P - 256'd1};
        issue(pm1w * pm1w, 256'd1, -1);
        wait_fin();
        issue({512{1'b1}}, ref_mod({512{1'b1}}), -1);

        // Strobe during FOLD with a different operand must be ignored.
        red_vld_i = 1'b1;
        red_d_i   = 512'd12345;
        @(posedge clk); #1;
        red_vld_i = 1'b0;
        wait_fin();

        // Strobe coincident with the done pulse is accepted.
        v = rnd512();
        issue(v, ref_mod(v), -1);
        wait_fin();

        // Continuously held strobe restarts every N+3 cycles.
        red_vld_i = 1'b1;
        red_d_i   = 512'd7;
        push(256'd7, 2);
        for (int k = 0; k < 4; k++) begin
            wait_fin();
            if (k < 3) push(256'd7, 2);
            else red_vld_i = 1'b0;
        end
        @(posedge clk); #1;

        // Reset during FOLD aborts the operation without a done pulse.
        issue({512{1'b1}}, 256'd0, -1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("midrst_busy", 256'(red_busy_o), 256'(0));
        check("midrst_fin",  256'(red_fin_o),  256'(0));
        check("midrst_r",    red_r_o,          256'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("postrst_busy", 256'(red_busy_o), 256'(0));
        check("postrst_r",    red_r_o,          256'(0));

        // Randomized back-to-back traffic.
        for (int i = 0; i < NUM_RAND; i++) begin
            v = rnd512();
            issue(v, ref_mod(v), (v[511:256] == '0) ? 2 : -1);
            wait_fin();
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 256'(q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
